// File: rtl/nseq_pkg.sv
// Shared constants for the microcode next-state sequencer: address width and NS select codes.
package nseq_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    NS_ENC   = 3'b000,
    NS_FETCH = 3'b001,
    NS_COND  = 3'b010,
    NS_INC   = 3'b011,
    NS_JUMP  = 3'b100,
    NS_CALL  = 3'b101,
    NS_RET   = 3'b110,
    NS_WAIT  = 3'b111
  } ns_e;

endpackage

// File: rtl/addr_incrementer.sv
// Enabled register holding the selected next address plus one (wraps mod 2^W).
module addr_incrementer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] reset_addr,
  input  logic [W-1:0] next_addr,
  output logic [W-1:0] inc_q
);

  logic [W-1:0] inc_d;

  // NOTE: inc_d gets its hold value first so every path assigns it; no latch is inferred.
  always_comb begin
    inc_d = inc_q;
    if (reset)   inc_d = reset_addr + W'(1);
    else if (en) inc_d = next_addr + W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    inc_q <= inc_d;
  end

endmodule

// File: rtl/next_state_sequencer.sv
// Microcode next-address sequencer: NS-selected address mux, State register, optional
// one-deep subroutine return register (enabled by defining NSEQ_SUBROUTINE_EN).
module next_state_sequencer
  import nseq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = 8'h00,
  parameter logic [ADDR_W-1:0] FETCH_ADDR = 8'h01
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Enc,
  input  logic [ADDR_W-1:0] CR,
  input  logic [2:0]        NS,
  input  logic              Cond,
  input  logic              Inv,
  input  logic              Stall,
  output logic [ADDR_W-1:0] State,
  output logic [ADDR_W-1:0] IncQ,
  output logic              RetValid
);

  logic [ADDR_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0] next_addr;
  logic              cond_eff;
  logic              advance;
  ns_e               ns;

  assign ns       = ns_e'(NS);
  assign cond_eff = Cond ^ Inv;
  assign advance  = ~Stall;

`ifdef NSEQ_SUBROUTINE_EN
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic              ret_valid_q, ret_valid_d;
`endif

  always_comb begin
    next_addr = IncQ;
    unique case (ns)
      NS_ENC:   next_addr = Enc;
      NS_FETCH: next_addr = FETCH_ADDR;
      NS_COND:  next_addr = cond_eff ? CR : IncQ;
      NS_INC:   next_addr = IncQ;
      NS_JUMP:  next_addr = CR;
      NS_CALL:  next_addr = CR;
`ifdef NSEQ_SUBROUTINE_EN
      NS_RET:   next_addr = ret_valid_q ? ret_addr_q : IncQ;
`else
      NS_RET:   next_addr = IncQ;
`endif
      NS_WAIT:  next_addr = cond_eff ? IncQ : state_q;
      default:  next_addr = IncQ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (reset)        state_d = RESET_ADDR;
    else if (advance) state_d = next_addr;
  end

`ifdef NSEQ_SUBROUTINE_EN
  always_comb begin
    ret_addr_d  = ret_addr_q;
    ret_valid_d = ret_valid_q;
    if (reset) begin
      ret_addr_d  = '0;
      ret_valid_d = 1'b0;
    end else if (advance) begin
      if (ns == NS_CALL) begin
        // One-deep: a nested call simply overwrites the saved address.
        ret_addr_d  = IncQ;
        ret_valid_d = 1'b1;
      end else if (ns == NS_RET) begin
        ret_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    ret_addr_q  <= ret_addr_d;
    ret_valid_q <= ret_valid_d;
  end

  assign RetValid = ret_valid_q;
`else
  assign RetValid = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    state_q <= state_d;
  end

  addr_incrementer #(.W(ADDR_W)) u_inc (
    .clk        (CLK),
    .reset      (reset),
    .en         (advance),
    .reset_addr (RESET_ADDR),
    .next_addr  (next_addr),
    .inc_q      (IncQ)
  );

  assign State = state_q;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Scoreboard bench for next_state_sequencer: driver queues expected post-edge outputs,
// a negedge monitor pops and compares them.
module tb_next_state_sequencer;

  typedef struct {
    logic [7:0] st;
    logic [7:0] inc;
    logic       rv;
  } exp_t;

`ifdef NSEQ_SUBROUTINE_EN
  localparam logic SUB = 1'b1;
`else
  localparam logic SUB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] enc = '0;
  logic [7:0] cr = '0;
  logic [2:0] ns = 3'b011;
  logic       cond = 1'b0;
  logic       inv = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] state;
  logic [7:0] incq;
  logic       ret_valid;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    failed = 0;

  next_state_sequencer dut (
    .CLK      (clk),
    .reset    (reset),
    .Enc      (enc),
    .CR       (cr),
    .NS       (ns),
    .Cond     (cond),
    .Inv      (inv),
    .Stall    (stall),
    .State    (state),
    .IncQ     (incq),
    .RetValid (ret_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input exp_t e);
    tests++;
    if (state !== e.st || incq !== e.inc || ret_valid !== e.rv) begin
      failed++;
      $display("FAIL %s: got State=%02h IncQ=%02h RetValid=%0b, expected State=%02h IncQ=%02h RetValid=%0b",
               nm, state, incq, ret_valid, e.st, e.inc, e.rv);
    end
  endtask

  // Monitor: outputs are registered, so the negedge after each edge shows that edge's result.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, e);
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic stl, input logic [2:0] code,
                     input logic [7:0] e_in, input logic [7:0] c_in, input logic cd, input logic iv,
                     input logic [7:0] e_st, input logic [7:0] e_inc, input logic e_rv);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; ns = code; enc = e_in; cr = c_in; cond = cd; inv = iv;
    @(posedge clk);
    e.st = e_st; e.inc = e_inc; e.rv = e_rv;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    // Reset and free-running increment
    cyc("reset",      1, 0, 3'b011, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 0);
    cyc("inc1",       0, 0, 3'b011, 8'h00, 8'h00, 0, 0, 8'h01, 8'h02, 0);
    cyc("inc2",       0, 0, 3'b011, 8'h00, 8'h00, 0, 0, 8'h02, 8'h03, 0);
    // Conditional branch with Inv
    cyc("jump10",     0, 0, 3'b100, 8'h00, 8'h10, 0, 0, 8'h10, 8'h11, 0);
    cyc("cbr_taken",  0, 0, 3'b010, 8'h00, 8'h40, 1, 0, 8'h40, 8'h41, 0);
    cyc("jump10b",    0, 0, 3'b100, 8'h00, 8'h10, 0, 0, 8'h10, 8'h11, 0);
    cyc("cbr_inv",    0, 0, 3'b010, 8'h00, 8'h40, 1, 1, 8'h11, 8'h12, 0);
    cyc("cbr_inv0",   0, 0, 3'b010, 8'h00, 8'h40, 0, 1, 8'h40, 8'h41, 0);
    cyc("cbr_nt",     0, 0, 3'b010, 8'h00, 8'h70, 0, 0, 8'h41, 8'h42, 0);
    // Call / Return
    cyc("jump20",     0, 0, 3'b100, 8'h00, 8'h20, 0, 0, 8'h20, 8'h21, 0);
    cyc("call80",     0, 0, 3'b101, 8'h00, 8'h80, 0, 0, 8'h80, 8'h81, SUB);
`ifdef NSEQ_SUBROUTINE_EN
    cyc("ret",        0, 0, 3'b110, 8'h00, 8'h00, 0, 0, 8'h21, 8'h22, 0);
    cyc("ret_empty",  0, 0, 3'b110, 8'h00, 8'h00, 0, 0, 8'h22, 8'h23, 0);
    cyc("call90",     0, 0, 3'b101, 8'h00, 8'h90, 0, 0, 8'h90, 8'h91, 1);
    cyc("call_a0",    0, 0, 3'b101, 8'h00, 8'hA0, 0, 0, 8'hA0, 8'hA1, 1);
    cyc("ret_ovw",    0, 0, 3'b110, 8'h00, 8'h00, 0, 0, 8'h91, 8'h92, 0);
    cyc("call_b0",    0, 0, 3'b101, 8'h00, 8'hB0, 0, 0, 8'hB0, 8'hB1, 1);
    cyc("rst_call",   1, 0, 3'b101, 8'h00, 8'hC0, 0, 0, 8'h00, 8'h01, 0);
`else
    cyc("ret_as_inc", 0, 0, 3'b110, 8'h00, 8'h00, 0, 0, 8'h81, 8'h82, 0);
`endif
    // Wait
    cyc("jump30",     0, 0, 3'b100, 8'h00, 8'h30, 0, 0, 8'h30, 8'h31, 0);
    for (int i = 0; i < 3; i++)
      cyc("wait_hold", 0, 0, 3'b111, 8'h00, 8'hEE, 0, 0, 8'h30, 8'h31, 0);
    cyc("wait_go",    0, 0, 3'b111, 8'h00, 8'hEE, 1, 0, 8'h31, 8'h32, 0);
    cyc("wait_inv",   0, 0, 3'b111, 8'h00, 8'hEE, 0, 1, 8'h32, 8'h33, 0);
    // Stall then Encoder
    cyc("stall1",     0, 1, 3'b000, 8'h55, 8'h00, 0, 0, 8'h32, 8'h33, 0);
    cyc("stall2",     0, 1, 3'b000, 8'h55, 8'h00, 0, 0, 8'h32, 8'h33, 0);
    cyc("enc55",      0, 0, 3'b000, 8'h55, 8'h00, 0, 0, 8'h55, 8'h56, 0);
    cyc("fetch",      0, 0, 3'b001, 8'h00, 8'h00, 0, 0, 8'h01, 8'h02, 0);
    // Wrap and reset priority
    cyc("jumpFF",     0, 0, 3'b100, 8'h00, 8'hFF, 0, 0, 8'hFF, 8'h00, 0);
    cyc("wrap",       0, 0, 3'b011, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 0);
    cyc("jump40",     0, 0, 3'b100, 8'h00, 8'h40, 0, 0, 8'h40, 8'h41, 0);
    cyc("wait40",     0, 0, 3'b111, 8'h00, 8'h00, 0, 0, 8'h40, 8'h41, 0);
    cyc("rst_stall",  1, 1, 3'b111, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 0);
    cyc("post_rst",   0, 0, 3'b011, 8'h00, 8'h00, 0, 0, 8'h01, 8'h02, 0);

    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        tests++;
        failed++;
        $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
